// File: rtl/rc4_phase_sequencer.sv
// Sequences the RC4 INIT, SHUFFLE and DECRYPT engines and owns the
// single-port S-RAM write port, muxing it to whichever engine is running.
module rc4_phase_sequencer #(
    parameter int RAM_WIDTH      = 8,
    parameter int RAM_LENGTH     = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            phase,
    output logic                  init_start,
    output logic                  shuf_start,
    output logic                  dec_start,
    input  logic                  init_finished,
    input  logic                  shuf_finished,
    input  logic                  dec_finished,
    input  logic                  init_we,
    input  logic [RAM_LENGTH-1:0] init_addr,
    input  logic [RAM_WIDTH-1:0]  init_din,
    input  logic                  shuf_we,
    input  logic [RAM_LENGTH-1:0] shuf_addr,
    input  logic [RAM_WIDTH-1:0]  shuf_din,
    input  logic                  dec_we,
    input  logic [RAM_LENGTH-1:0] dec_addr,
    input  logic [RAM_WIDTH-1:0]  dec_din,
    output logic                  ram_we,
    output logic [RAM_LENGTH-1:0] ram_addr,
    output logic [RAM_WIDTH-1:0]  ram_din
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT_GO,
        S_INIT_RUN,
        S_SHUF_GO,
        S_SHUF_RUN,
        S_DEC_GO,
        S_DEC_RUN,
        S_DONE,
        S_ERROR
    } state_t;

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fin_prev_q, fin_prev_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic [1:0]    phase_q, phase_d;
    logic          init_start_q, init_start_d;
    logic          shuf_start_q, shuf_start_d;
    logic          dec_start_q, dec_start_d;

    logic fin_sel;
    logic fin_edge;
    logic timed_out;

    // Finish line of the engine owning the current phase (GO and RUN).
    always_comb begin
        fin_sel = 1'b0;
        case (state_q)
            S_INIT_GO, S_INIT_RUN: fin_sel = init_finished;
            S_SHUF_GO, S_SHUF_RUN: fin_sel = shuf_finished;
            S_DEC_GO,  S_DEC_RUN:  fin_sel = dec_finished;
            default:               fin_sel = 1'b0;
        endcase
    end

    // Sampling the level during GO makes a finish already high on entry stale.
    assign fin_prev_d = fin_sel;
    assign fin_edge   = fin_sel & ~fin_prev_q;
    assign timed_out  = (cnt_q >= TO_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) state_d = S_INIT_GO;
                end
                S_INIT_GO: begin
                    state_d = S_INIT_RUN;
                    cnt_d   = CW'(1);
                end
                S_SHUF_GO: begin
                    state_d = S_SHUF_RUN;
                    cnt_d   = CW'(1);
                end
                S_DEC_GO: begin
                    state_d = S_DEC_RUN;
                    cnt_d   = CW'(1);
                end
                S_INIT_RUN, S_SHUF_RUN, S_DEC_RUN: begin
                    if (fin_edge) begin
                        case (state_q)
                            S_INIT_RUN: state_d = S_SHUF_GO;
                            S_SHUF_RUN: state_d = S_DEC_GO;
                            default:    state_d = S_DONE;
                        endcase
                    end else if (timed_out) begin
                        state_d = S_ERROR;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they are registered.
    always_comb begin
        busy_d       = 1'b0;
        done_d       = 1'b0;
        error_d      = 1'b0;
        phase_d      = 2'd0;
        init_start_d = 1'b0;
        shuf_start_d = 1'b0;
        dec_start_d  = 1'b0;
        case (state_d)
            S_INIT_GO: begin
                busy_d       = 1'b1;
                phase_d      = 2'd1;
                init_start_d = 1'b1;
            end
            S_INIT_RUN: begin
                busy_d  = 1'b1;
                phase_d = 2'd1;
            end
            S_SHUF_GO: begin
                busy_d       = 1'b1;
                phase_d      = 2'd2;
                shuf_start_d = 1'b1;
            end
            S_SHUF_RUN: begin
                busy_d  = 1'b1;
                phase_d = 2'd2;
            end
            S_DEC_GO: begin
                busy_d      = 1'b1;
                phase_d     = 2'd3;
                dec_start_d = 1'b1;
            end
            S_DEC_RUN: begin
                busy_d  = 1'b1;
                phase_d = 2'd3;
            end
            S_DONE:  done_d  = 1'b1;
            S_ERROR: error_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            fin_prev_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            phase_q      <= 2'd0;
            init_start_q <= 1'b0;
            shuf_start_q <= 1'b0;
            dec_start_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            fin_prev_q   <= fin_prev_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            phase_q      <= phase_d;
            init_start_q <= init_start_d;
            shuf_start_q <= shuf_start_d;
            dec_start_q  <= dec_start_d;
        end
    end

    // Zero-latency port mux; abort and the finishing edge silence writes at once.
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        if (!abort) begin
            case (state_q)
                S_INIT_RUN: begin
                    ram_we   = init_we & ~fin_edge;
                    ram_addr = init_addr;
                    ram_din  = init_din;
                end
                S_SHUF_RUN: begin
                    ram_we   = shuf_we & ~fin_edge;
                    ram_addr = shuf_addr;
                    ram_din  = shuf_din;
                end
                S_DEC_RUN: begin
                    ram_we   = dec_we & ~fin_edge;
                    ram_addr = dec_addr;
                    ram_din  = dec_din;
                end
                default: ;
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign phase      = phase_q;
    assign init_start = init_start_q;
    assign shuf_start = shuf_start_q;
    assign dec_start  = dec_start_q;

endmodule

// File: tb/tb_rc4_phase_sequencer.sv
// Directed bench for rc4_phase_sequencer: nominal run, mux isolation,
// stale finish, timeout (second instance), abort and async reset.
module tb_rc4_phase_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, start, abort;
    logic       init_finished, shuf_finished, dec_finished;
    logic       init_we, shuf_we, dec_we;
    logic [7:0] init_addr, shuf_addr, dec_addr;
    logic [7:0] init_din, shuf_din, dec_din;

    logic       busy, done, error, init_start, shuf_start, dec_start, ram_we;
    logic [1:0] phase;
    logic [7:0] ram_addr, ram_din;

    logic       t_busy, t_done, t_error, t_init_start, t_shuf_start;
    logic       t_dec_start, t_ram_we;
    logic [1:0] t_phase;
    logic [7:0] t_ram_addr, t_ram_din;

    int checks = 0;
    int errors = 0;

    rc4_phase_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .busy(busy), .done(done), .error(error), .phase(phase),
        .init_start(init_start), .shuf_start(shuf_start),
        .dec_start(dec_start),
        .init_finished(init_finished), .shuf_finished(shuf_finished),
        .dec_finished(dec_finished),
        .init_we(init_we), .init_addr(init_addr), .init_din(init_din),
        .shuf_we(shuf_we), .shuf_addr(shuf_addr), .shuf_din(shuf_din),
        .dec_we(dec_we), .dec_addr(dec_addr), .dec_din(dec_din),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din)
    );

    rc4_phase_sequencer #(.TIMEOUT_CYCLES(16)) dut_t (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .busy(t_busy), .done(t_done), .error(t_error), .phase(t_phase),
        .init_start(t_init_start), .shuf_start(t_shuf_start),
        .dec_start(t_dec_start),
        .init_finished(init_finished), .shuf_finished(shuf_finished),
        .dec_finished(dec_finished),
        .init_we(init_we), .init_addr(init_addr), .init_din(init_din),
        .shuf_we(shuf_we), .shuf_addr(shuf_addr), .shuf_din(shuf_din),
        .dec_we(dec_we), .dec_addr(dec_addr), .dec_din(dec_din),
        .ram_we(t_ram_we), .ram_addr(t_ram_addr), .ram_din(t_ram_din)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        init_finished = 1'b0; shuf_finished = 1'b0; dec_finished = 1'b0;
        init_we = 1'b0; shuf_we = 1'b0; dec_we = 1'b0;
        init_addr = 8'h00; shuf_addr = 8'h00; dec_addr = 8'h00;
        init_din = 8'h00; shuf_din = 8'h00; dec_din = 8'h00;

        // Reset state
        #2;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_phase", 32'(phase), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_init_start", 32'(init_start), 0);
        chk("rst_ram_we", 32'(ram_we), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        tick();
        chk("idle_busy", 32'(busy), 0);

        // Nominal sequence with mux checks
        start = 1'b1;
        tick();
        chk("ig_init_start", 32'(init_start), 1);
        chk("ig_phase", 32'(phase), 1);
        chk("ig_busy", 32'(busy), 1);
        start = 1'b0;
        tick();
        chk("ir_init_start", 32'(init_start), 0);
        init_we = 1'b1; init_addr = 8'h11; init_din = 8'h22;
        #1;
        chk("ir_ram_we", 32'(ram_we), 1);
        chk("ir_ram_addr", 32'(ram_addr), 32'h11);
        repeat (257) tick();
        chk("ir_phase_hold", 32'(phase), 1);
        init_finished = 1'b1;
        #1;
        chk("ir_edge_we_off", 32'(ram_we), 0);
        tick();
        chk("sg_shuf_start", 32'(shuf_start), 1);
        chk("sg_phase", 32'(phase), 2);
        init_finished = 1'b0; init_we = 1'b0;
        tick();
        chk("sr_shuf_start", 32'(shuf_start), 0);
        init_we = 1'b1; init_addr = 8'hAA;
        shuf_we = 1'b1; shuf_addr = 8'h05; shuf_din = 8'h3C;
        #1;
        chk("mux_addr", 32'(ram_addr), 32'h05);
        chk("mux_we", 32'(ram_we), 1);
        chk("mux_din", 32'(ram_din), 32'h3C);
        repeat (1027) tick();
        chk("sr_phase_hold", 32'(phase), 2);
        shuf_finished = 1'b1;
        tick();
        chk("dg_dec_start", 32'(dec_start), 1);
        chk("dg_phase", 32'(phase), 3);
        shuf_finished = 1'b0; shuf_we = 1'b0; init_we = 1'b0;
        repeat (199) tick();
        chk("dr_phase_hold", 32'(phase), 3);
        dec_finished = 1'b1;
        tick();
        chk("done_done", 32'(done), 1);
        chk("done_busy", 32'(busy), 0);
        chk("done_phase", 32'(phase), 0);
        dec_finished = 1'b0;
        init_we = 1'b1; shuf_we = 1'b1; dec_we = 1'b1;
        dec_addr = 8'h77; dec_din = 8'h55;
        #1;
        chk("done_ram_we", 32'(ram_we), 0);
        chk("done_ram_addr", 32'(ram_addr), 0);
        chk("done_ram_din", 32'(ram_din), 0);
        init_we = 1'b0; shuf_we = 1'b0; dec_we = 1'b0;

        // Restart from DONE, then stale shuffle finish
        start = 1'b1;
        tick();
        chk("rs_init_start", 32'(init_start), 1);
        chk("rs_done_clr", 32'(done), 0);
        start = 1'b0;
        tick();
        init_finished = 1'b1;
        tick();
        init_finished = 1'b0;
        shuf_finished = 1'b1;
        repeat (3) tick();
        chk("stale_phase", 32'(phase), 2);
        chk("stale_busy", 32'(busy), 1);
        shuf_finished = 1'b0;
        tick();
        chk("stale_low_phase", 32'(phase), 2);
        shuf_finished = 1'b1;
        tick();
        chk("stale_rise_phase", 32'(phase), 3);
        chk("stale_dec_start", 32'(dec_start), 1);
        shuf_finished = 1'b0;
        tick();

        // Timeout on the 16-cycle instance
        abort = 1'b1;
        tick();
        chk("ab_t_busy", 32'(t_busy), 0);
        abort = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        init_finished = 1'b1;
        tick();
        init_finished = 1'b0;
        tick();
        shuf_finished = 1'b1;
        tick();
        chk("to_dec_start", 32'(t_dec_start), 1);
        shuf_finished = 1'b0;
        dec_we = 1'b1;
        repeat (15) tick();
        chk("to_pre_phase", 32'(t_phase), 3);
        chk("to_pre_error", 32'(t_error), 0);
        tick();
        chk("to_error", 32'(t_error), 1);
        chk("to_busy", 32'(t_busy), 0);
        chk("to_phase", 32'(t_phase), 0);
        #1;
        chk("to_ram_we", 32'(t_ram_we), 0);
        dec_we = 1'b0;
        start = 1'b1;
        tick();
        chk("to_restart", 32'(t_init_start), 1);
        chk("to_err_clr", 32'(t_error), 0);
        start = 1'b0;

        // Abort mid-shuffle
        abort = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        init_finished = 1'b1;
        tick();
        init_finished = 1'b0;
        tick();
        shuf_we = 1'b1; shuf_addr = 8'h05;
        #1;
        chk("ab_pre_we", 32'(ram_we), 1);
        abort = 1'b1;
        #1;
        chk("ab_same_we", 32'(ram_we), 0);
        chk("ab_same_addr", 32'(ram_addr), 0);
        tick();
        chk("ab_idle_busy", 32'(busy), 0);
        chk("ab_idle_phase", 32'(phase), 0);
        start = 1'b1;
        tick();
        chk("ab_start_busy", 32'(busy), 0);
        chk("ab_start_init", 32'(init_start), 0);
        abort = 1'b0; start = 1'b0; shuf_we = 1'b0;

        // Async reset mid-decrypt
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        init_finished = 1'b1;
        tick();
        init_finished = 1'b0;
        tick();
        shuf_finished = 1'b1;
        tick();
        shuf_finished = 1'b0;
        tick();
        dec_we = 1'b1; dec_addr = 8'h9C;
        #1;
        chk("ar_pre_we", 32'(ram_we), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_busy", 32'(busy), 0);
        chk("ar_phase", 32'(phase), 0);
        chk("ar_ram_we", 32'(ram_we), 0);
        chk("ar_ram_addr", 32'(ram_addr), 0);
        dec_we = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b1;
        tick();
        chk("ar_init_start", 32'(init_start), 1);
        start = 1'b0;
        tick();
        init_finished = 1'b1;
        tick();
        init_finished = 1'b0;
        chk("ar_shuf_start", 32'(shuf_start), 1);
        tick();
        shuf_finished = 1'b1;
        tick();
        shuf_finished = 1'b0;
        chk("ar_dec_start", 32'(dec_start), 1);
        tick();
        dec_finished = 1'b1;
        tick();
        dec_finished = 1'b0;
        chk("ar_done", 32'(done), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
